pll_loop_ctrl: RTL
==================

# pll_loop_ctrl

Digital loop controller that drives the 5-bit fine-control word of the PLL's digitally controlled oscillator. It consumes early/late decisions from the bang-bang phase detector, already synchronised to the reference clock. It then runs a successive-approximation (SAR) coarse acquisition, followed by a proportional-integral (PI) tracking loop. It sits directly upstream of the oscillator and drives its DFINE input; it also reports lock status to the PLL top level.

## Interface
- NUM_BITS, 5: width of DFINE.
- FRAC_BITS, 4: fractional bits below the DFINE LSB in the integrator.
- KI, 1: integrator step per phase-detector sample, in fractional LSBs (1..2^FRAC_BITS).
- KP, 1: proportional kick, in whole DFINE LSBs (0..3).
- DECIM, 7: phase-detector samples per SAR vote (odd, 1..31).
- LOCK_CNT, 32: consecutive valid samples with a stable integer code required to declare lock (2..255).
- CLK  in  1  reference clock; all logic is on the rising edge.
- nRST  in  1  synchronous, active-low reset.
- EN  in  1  loop enable; low forces IDLE.
- PD_VALID  in  1  one-cycle strobe; PD_LATE is valid in that cycle.
- PD_LATE  in  1  1 = oscillator lags, so increase frequency; 0 = oscillator leads, so decrease frequency.
- DFINE  out  NUM_BITS  oscillator control word, registered.
- LOCK  out  1  lock indicator, registered.
- SAT  out  1  high while the integrator is clamped at either rail.

## Operation
- Reset and idle state: nRST=0, or EN=0 on any edge, forces the following.
  - State goes to IDLE.
  - DFINE = 2^(NUM_BITS-1) (midscale; 16 by default).
  - LOCK=0, SAT=0.
  - Vote counter, bit index, integrator and lock counter are all cleared.
- States are IDLE → ACQ → TRACK ↔ LOCKED. Leaving ACQ, TRACK or LOCKED happens only through EN=0 or nRST=0.
- IDLE to ACQ: EN=1 moves the block to ACQ on the next edge.
  - Bit index = NUM_BITS-1.
  - DFINE = midscale, which is the trial with the MSB set.
- ACQ behaviour:
  - Each PD_VALID adds +1 to a signed vote when PD_LATE=1, and -1 when PD_LATE=0.
  - After DECIM samples: vote > 0 keeps the trial bit; vote ≤ 0 clears it (a tie counts as lead).
  - Then the next lower bit is set as the new trial, and the vote is cleared.
  - After bit 0 is decided, the block enters TRACK. The integrator is loaded with {DFINE, FRAC_BITS'b0} plus half a DFINE LSB (2^(FRAC_BITS-1)).
- TRACK and LOCKED behaviour, on each PD_VALID:
  - The integrator adds +KI when PD_LATE=1 and -KI when PD_LATE=0.
  - It saturates to [0, 2^(NUM_BITS+FRAC_BITS)-1].
  - SAT=1 whenever the integrator sits at either rail after the update.
- DFINE in TRACK and LOCKED:
  - DFINE = clamp(int_hi ± KP, 0, 2^NUM_BITS-1), where int_hi is the integer part of the integrator.
  - The sign of the KP term follows the current sample.
  - DFINE only changes on PD_VALID cycles.
- Lock detect:
  - In TRACK, the lock counter increments on each PD_VALID whose int_hi equals the previous int_hi, and resets to 0 otherwise.
  - When the count reaches LOCK_CNT: go to LOCKED, set LOCK=1, and capture ref = int_hi.
- Loss of lock: in LOCKED, an int_hi with |int_hi − ref| > 1 sends the block back to TRACK, with LOCK=0 and the counter cleared.
- PD_VALID while in IDLE is ignored.

## Timing
- All outputs are registered. DFINE, LOCK and SAT update on the edge that samples PD_VALID=1, so they are visible the next cycle (1-cycle latency).
- SAR completes after NUM_BITS·DECIM valid samples. The last decision and the TRACK entry happen on the same edge.
- EN falling mid-ACQ or mid-LOCKED: IDLE values appear on the next edge, and no partial update is applied.
- nRST=0 takes priority over EN and PD_VALID in the same cycle.
- There is no back-pressure: PD_VALID may be asserted on consecutive cycles, and every strobe is consumed.

## Structure
- pll_pkg holds:
  - typedef enum logic [1:0] {IDLE, ACQ, TRACK, LOCKED} loop_state_t;
  - the midscale constant function;
  - the saturating add helper.
- Sub-module pll_sat_accum: a signed-step, saturating (NUM_BITS+FRAC_BITS)-bit accumulator with load, step and SAT flag.
- The SAR, lock detect and FSM live in pll_loop_ctrl.

## Test plan
- Reset and idle: hold nRST=0 for 3 cycles, then EN=0 → DFINE=16, LOCK=0, SAT=0, and stays there under random PD_VALID.
- SAR all-late: 35 samples with PD_LATE=1 → DFINE passes through 16, 24, 28, 30, 31 and ends at 31 in TRACK.
- SAR all-lead: 35 samples with PD_LATE=0 → DFINE passes through 16, 8, 4, 2, 1 and ends at 0 in TRACK.
- Integrator saturation: all-late drive continues in TRACK → SAT=1, integrator = 511 and DFINE = 31 with KP=1 clamped; a single lead sample → DFINE = 30.
- Lock and loss of lock: after SAR to 19, drive alternating late/lead → LOCK=1 after exactly 32 samples; then 40 consecutive lead samples → int_hi reaches 17 and LOCK=0 on that edge.
- Mid-operation disable: EN=0 for 1 cycle during the bit-2 vote → DFINE=16 the next cycle; re-enable restarts SAR from the MSB.

Source files
------------

// File: rtl/pll_pkg.sv
// Shared types and helpers for the PLL digital loop controller.
package pll_pkg;

    typedef enum logic [1:0] {IDLE, ACQ, TRACK, LOCKED} loop_state_t;

    function automatic int unsigned midscale(input int unsigned nbits);
        return 32'd1 << (nbits - 1);
    endfunction

    // Add a signed step and clamp the result to [0, hi].
    function automatic int sat_add(input int a, input int b, input int hi);
        int s;
        s = a + b;
        if (s < 0) return 0;
        if (s > hi) return hi;
        return s;
    endfunction

endpackage

// File: rtl/pll_sat_accum.sv
// Saturating loop integrator: clear, load, or +/-STEP with rail flag.
// acc_nxt_o exposes the post-update value so the owner can act on it in the same edge.
module pll_sat_accum
    import pll_pkg::*;
#(
    parameter int W    = 9,
    parameter int STEP = 1
) (
    input  logic         clk_i,
    input  logic         nrst_i,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         step_en_i,
    input  logic         step_up_i,
    output logic [W-1:0] acc_o,
    output logic [W-1:0] acc_nxt_o,
    output logic         sat_o
);

    localparam int TOP = (1 << W) - 1;

    logic [W-1:0] acc_q, acc_d;
    logic         sat_q, sat_d;

    always_comb begin
        acc_d = acc_q;
        sat_d = sat_q;
        if (clr_i) begin
            acc_d = '0;
            sat_d = 1'b0;
        end else if (load_i) begin
            acc_d = load_val_i;
            sat_d = 1'b0;
        end else if (step_en_i) begin
            acc_d = W'(sat_add(int'({1'b0, acc_q}), step_up_i ? STEP : -STEP, TOP));
            sat_d = (acc_d == '0) || (acc_d == '1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!nrst_i) begin
            acc_q <= '0;
            sat_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            sat_q <= sat_d;
        end
    end

    assign acc_o     = acc_q;
    assign acc_nxt_o = acc_d;
    assign sat_o     = sat_q;

endmodule

// File: rtl/pll_loop_ctrl.sv
// DCO fine-word loop controller: SAR coarse acquisition, then PI tracking
// with lock detection driven by bang-bang phase-detector samples.
module pll_loop_ctrl
    import pll_pkg::*;
#(
    parameter int NUM_BITS  = 5,
    parameter int FRAC_BITS = 4,
    parameter int KI        = 1,
    parameter int KP        = 1,
    parameter int DECIM     = 7,
    parameter int LOCK_CNT  = 32
) (
    input  logic                clk_i,
    input  logic                nrst_i,
    input  logic                en_i,
    input  logic                pd_valid_i,
    input  logic                pd_late_i,
    output logic [NUM_BITS-1:0] dfine_o,
    output logic                lock_o,
    output logic                sat_o
);

    localparam int W  = NUM_BITS + FRAC_BITS;
    localparam int BW = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
    localparam int DMAX = (1 << NUM_BITS) - 1;
    localparam logic [NUM_BITS-1:0] MID      = NUM_BITS'(midscale(NUM_BITS));
    localparam logic [W-1:0]        HALF     = W'(1 << (FRAC_BITS - 1));
    localparam logic [4:0]          DEC_LAST = 5'(DECIM - 1);
    localparam logic [7:0]          LOCK_TGT = 8'(LOCK_CNT);

    loop_state_t         state_q;
    logic [NUM_BITS-1:0] dfine_q, ref_q;
    logic                lock_q;
    logic signed [5:0]   vote_q;
    logic [4:0]          dec_cnt_q;
    logic [BW-1:0]       bit_q;
    logic [7:0]          lock_cnt_q;

    logic                active;
    logic signed [5:0]   vote_nxt;
    logic                last_smp;
    logic [NUM_BITS-1:0] sar_word, sar_next, dfine_trk;
    logic [W-1:0]        acc, acc_nxt, load_val;
    logic [NUM_BITS-1:0] hi_cur, hi_nxt;
    logic                acc_load, acc_step, lost;
    int                  hi_diff;

    assign active = nrst_i && en_i;

    always_comb begin
        vote_nxt = vote_q + (pd_late_i ? 6'sd1 : -6'sd1);
        last_smp = (dec_cnt_q == DEC_LAST);
        sar_word = dfine_q;
        if (vote_nxt <= 6'sd0) sar_word[bit_q] = 1'b0;
        sar_next = sar_word;
        if (bit_q != '0) sar_next[bit_q - 1'b1] = 1'b1;
        load_val = W'({sar_word, {FRAC_BITS{1'b0}}}) + HALF;
    end

    assign acc_load = active && (state_q == ACQ) && pd_valid_i && last_smp && (bit_q == '0);
    assign acc_step = active && ((state_q == TRACK) || (state_q == LOCKED)) && pd_valid_i;

    pll_sat_accum #(.W(W), .STEP(KI)) u_accum (
        .clk_i      (clk_i),
        .nrst_i     (nrst_i),
        .clr_i      (!en_i),
        .load_i     (acc_load),
        .load_val_i (load_val),
        .step_en_i  (acc_step),
        .step_up_i  (pd_late_i),
        .acc_o      (acc),
        .acc_nxt_o  (acc_nxt),
        .sat_o      (sat_o)
    );

    // Proportional kick follows the sign of the sample just consumed.
    always_comb begin
        hi_cur    = acc[W-1:FRAC_BITS];
        hi_nxt    = acc_nxt[W-1:FRAC_BITS];
        dfine_trk = NUM_BITS'(sat_add(int'({1'b0, hi_nxt}), pd_late_i ? KP : -KP, DMAX));
        hi_diff   = int'({1'b0, hi_nxt}) - int'({1'b0, ref_q});
        lost      = (hi_diff > 1) || (hi_diff < -1);
    end

    always_ff @(posedge clk_i) begin
        if (!active) begin
            state_q    <= IDLE;
            dfine_q    <= MID;
            lock_q     <= 1'b0;
            vote_q     <= '0;
            dec_cnt_q  <= '0;
            bit_q      <= '0;
            lock_cnt_q <= '0;
            ref_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= ACQ;
                    bit_q   <= BW'(NUM_BITS - 1);
                    dfine_q <= MID;
                end
                ACQ: if (pd_valid_i) begin
                    if (last_smp) begin
                        vote_q    <= '0;
                        dec_cnt_q <= '0;
                        if (bit_q == '0) begin
                            state_q    <= TRACK;
                            dfine_q    <= sar_word;
                            lock_cnt_q <= '0;
                        end else begin
                            dfine_q <= sar_next;
                            bit_q   <= bit_q - 1'b1;
                        end
                    end else begin
                        vote_q    <= vote_nxt;
                        dec_cnt_q <= dec_cnt_q + 5'd1;
                    end
                end
                TRACK: if (pd_valid_i) begin
                    dfine_q <= dfine_trk;
                    if (hi_nxt == hi_cur) begin
                        lock_cnt_q <= lock_cnt_q + 8'd1;
                        if (lock_cnt_q + 8'd1 == LOCK_TGT) begin
                            state_q <= LOCKED;
                            lock_q  <= 1'b1;
                            ref_q   <= hi_nxt;
                        end
                    end else begin
                        lock_cnt_q <= '0;
                    end
                end
                LOCKED: if (pd_valid_i) begin
                    dfine_q <= dfine_trk;
                    if (lost) begin
                        state_q    <= TRACK;
                        lock_q     <= 1'b0;
                        lock_cnt_q <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dfine_o = dfine_q;
    assign lock_o  = lock_q;

endmodule
